// File: rtl/mandel_stream_gen.sv
// Mandelbrot pixel-stream source: walks an X_SIZE x Y_SIZE raster, iterates z <- z^2 + c in
// signed fixed point, one iteration per cycle, and emits one AXI4-Stream beat per pixel.
module mandel_stream_gen #(
  parameter int X_SIZE     = 640,
  parameter int Y_SIZE     = 480,
  parameter int MAX_ITER   = 255,
  parameter int DATA_W     = 32,
  parameter int FRAC_BITS  = 28,
  parameter int TLAST_MODE = 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] cfg_re_min,
  input  logic signed [DATA_W-1:0] cfg_im_min,
  input  logic signed [DATA_W-1:0] cfg_re_step,
  input  logic signed [DATA_W-1:0] cfg_im_step,
  output logic [31:0]              out_stream_tdata,
  output logic [3:0]               out_stream_tkeep,
  output logic                     out_stream_tlast,
  output logic                     out_stream_tuser,
  output logic                     out_stream_tvalid,
  input  logic                     out_stream_tready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 1;
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
  localparam logic [7:0]    I_LAST = 8'(MAX_ITER - 1);
  localparam logic [SW-1:0] ESC_LIMIT = {{(SW-3){1'b0}}, 3'd4} << (2 * FRAC_BITS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_ITER = 2'd2, S_OUT = 2'd3} state_t;

  function automatic logic [23:0] palette(input logic [7:0] it);
    logic [7:0] g;
    g = it << 1;
    palette = {it, g, 8'd255 - it};
  endfunction

  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic signed [DATA_W-1:0] cr_q, cr_d, ci_q, ci_d, zr_q, zr_d, zi_q, zi_d;
  logic signed [DATA_W-1:0] re_min_q, re_min_d, im_min_q, im_min_d;
  logic signed [DATA_W-1:0] re_step_q, re_step_d, im_step_q, im_step_d;
  logic [7:0]  it_q, it_d;
  logic [31:0] tdata_q, tdata_d;
  logic tlast_q, tlast_d, tuser_q, tuser_d, tvalid_q, tvalid_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d;

  logic signed [PW-1:0] zr2_s, zi2_s, zrzi_s;
  logic [SW-1:0] mag_s;
  logic signed [SW-1:0] re_full_s, im_full_s;
  logic signed [DATA_W-1:0] zr_next_s, zi_next_s;
  logic eol_s, eof_s, beat_last_s, hs_s, start_s;

  // Full-precision products; squares are non-negative so the magnitude is zero-extended.
  assign zr2_s     = PW'(zr_q) * PW'(zr_q);
  assign zi2_s     = PW'(zi_q) * PW'(zi_q);
  assign zrzi_s    = PW'(zr_q) * PW'(zi_q);
  assign mag_s     = {1'b0, zr2_s} + {1'b0, zi2_s};
  assign re_full_s = {zr2_s[PW-1], zr2_s} - {zi2_s[PW-1], zi2_s};
  assign im_full_s = {zrzi_s, 1'b0};
  assign zr_next_s = DATA_W'(re_full_s >>> FRAC_BITS) + cr_q;
  assign zi_next_s = DATA_W'(im_full_s >>> FRAC_BITS) + ci_q;

  assign eol_s       = (x_q == X_LAST);
  assign eof_s       = eol_s && (y_q == Y_LAST);
  assign beat_last_s = (TLAST_MODE == 1) ? eol_s : eof_s;
  assign hs_s        = tvalid_q && out_stream_tready;
  assign start_s     = enable && ((state_q == S_IDLE) || ((state_q == S_OUT) && hs_s && eof_s));

  // Next-state, datapath and output-beat logic.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    it_d         = it_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    tvalid_d     = tvalid_q;
    frame_done_d = 1'b0;
    re_min_d     = start_s ? cfg_re_min  : re_min_q;
    im_min_d     = start_s ? cfg_im_min  : im_min_q;
    re_step_d    = start_s ? cfg_re_step : re_step_q;
    im_step_d    = start_s ? cfg_im_step : im_step_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          cr_d    = cfg_re_min;
          ci_d    = cfg_im_min;
          x_d     = {XW{1'b0}};
          y_d     = {YW{1'b0}};
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        zr_d    = {DATA_W{1'b0}};
        zi_d    = {DATA_W{1'b0}};
        it_d    = 8'd0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (mag_s > ESC_LIMIT) begin
          tdata_d  = {palette(it_q), 8'h00};
          tlast_d  = beat_last_s;
          tuser_d  = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
          tvalid_d = 1'b1;
          state_d  = S_OUT;
        end else if (it_q == I_LAST) begin
          tdata_d  = 32'h0000_0000;
          tlast_d  = beat_last_s;
          tuser_d  = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
          tvalid_d = 1'b1;
          state_d  = S_OUT;
        end else begin
          zr_d = zr_next_s;
          zi_d = zi_next_s;
          it_d = it_q + 8'd1;
        end
      end
      S_OUT: begin
        if (out_stream_tready) begin
          tvalid_d = 1'b0;
          state_d  = S_LOAD;
          if (!eol_s) begin
            x_d  = x_q + XW'(1'b1);
            cr_d = cr_q + re_step_q;
          end else if (!eof_s) begin
            x_d  = {XW{1'b0}};
            y_d  = y_q + YW'(1'b1);
            cr_d = re_min_q;
            ci_d = ci_q + im_step_q;
          end else begin
            // Frame end: the next frame always starts from freshly latched cfg.
            x_d          = {XW{1'b0}};
            y_d          = {YW{1'b0}};
            cr_d         = cfg_re_min;
            ci_d         = cfg_im_min;
            frame_done_d = 1'b1;
            state_d      = enable ? S_LOAD : S_IDLE;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      x_q          <= {XW{1'b0}};
      y_q          <= {YW{1'b0}};
      cr_q         <= {DATA_W{1'b0}};
      ci_q         <= {DATA_W{1'b0}};
      zr_q         <= {DATA_W{1'b0}};
      zi_q         <= {DATA_W{1'b0}};
      re_min_q     <= {DATA_W{1'b0}};
      im_min_q     <= {DATA_W{1'b0}};
      re_step_q    <= {DATA_W{1'b0}};
      im_step_q    <= {DATA_W{1'b0}};
      it_q         <= 8'd0;
      tdata_q      <= 32'h0000_0000;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      re_min_q     <= re_min_d;
      im_min_q     <= im_min_d;
      re_step_q    <= re_step_d;
      im_step_q    <= im_step_d;
      it_q         <= it_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      tvalid_q     <= tvalid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;
  assign busy              = busy_q;
  assign frame_done        = frame_done_q;

endmodule

// File: tb/tb_mandel_stream_gen.sv
// Bench for mandel_stream_gen: four instances (4x2 line-tlast, 4x2 frame-tlast, 1x1, 4x2 with
// MAX_ITER=1) checked every cycle against a real-arithmetic escape-time model.
module tb_mandel_stream_gen;

  localparam int  N   = 4;
  localparam real ONE = 268435456.0;
  localparam int  XS[N] = '{4, 4, 1, 4};
  localparam int  YS[N] = '{2, 2, 1, 2};
  localparam int  MI[N] = '{16, 16, 16, 1};

  logic aclk = 1'b0;
  logic aresetn;
  logic enable [N];
  logic signed [31:0] re_min [N], im_min [N], re_step [N], im_step [N];
  logic [31:0] tdata [N];
  logic [3:0]  tkeep [N];
  logic tlast [N], tuser [N], tvalid [N], tready [N], busy [N], fdone [N];

  real f_rm [N], f_rs [N], f_im [N], f_is [N];
  int  px [N], py [N], beats [N], since [N];
  logic gap_ok [N], pv [N], pr [N], pl [N], pu [N], fd_exp [N];
  logic [31:0] pd [N];
  logic [31:0] m_beat, p_beat;
  int  m_it, p_it, hold;
  int  n_tests = 0, n_fail = 0;
  logic stall_on;

  always #5 aclk = ~aclk;

  mandel_stream_gen #(.X_SIZE(4), .Y_SIZE(2), .MAX_ITER(16), .DATA_W(32), .FRAC_BITS(28), .TLAST_MODE(1)) u_d0 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable[0]),
    .cfg_re_min(re_min[0]), .cfg_im_min(im_min[0]), .cfg_re_step(re_step[0]), .cfg_im_step(im_step[0]),
    .out_stream_tdata(tdata[0]), .out_stream_tkeep(tkeep[0]), .out_stream_tlast(tlast[0]),
    .out_stream_tuser(tuser[0]), .out_stream_tvalid(tvalid[0]), .out_stream_tready(tready[0]),
    .busy(busy[0]), .frame_done(fdone[0]));

  mandel_stream_gen #(.X_SIZE(4), .Y_SIZE(2), .MAX_ITER(16), .DATA_W(32), .FRAC_BITS(28), .TLAST_MODE(0)) u_d1 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable[1]),
    .cfg_re_min(re_min[1]), .cfg_im_min(im_min[1]), .cfg_re_step(re_step[1]), .cfg_im_step(im_step[1]),
    .out_stream_tdata(tdata[1]), .out_stream_tkeep(tkeep[1]), .out_stream_tlast(tlast[1]),
    .out_stream_tuser(tuser[1]), .out_stream_tvalid(tvalid[1]), .out_stream_tready(tready[1]),
    .busy(busy[1]), .frame_done(fdone[1]));

  mandel_stream_gen #(.X_SIZE(1), .Y_SIZE(1), .MAX_ITER(16), .DATA_W(32), .FRAC_BITS(28), .TLAST_MODE(1)) u_d2 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable[2]),
    .cfg_re_min(re_min[2]), .cfg_im_min(im_min[2]), .cfg_re_step(re_step[2]), .cfg_im_step(im_step[2]),
    .out_stream_tdata(tdata[2]), .out_stream_tkeep(tkeep[2]), .out_stream_tlast(tlast[2]),
    .out_stream_tuser(tuser[2]), .out_stream_tvalid(tvalid[2]), .out_stream_tready(tready[2]),
    .busy(busy[2]), .frame_done(fdone[2]));

  mandel_stream_gen #(.X_SIZE(4), .Y_SIZE(2), .MAX_ITER(1), .DATA_W(32), .FRAC_BITS(28), .TLAST_MODE(1)) u_d3 (
    .aclk(aclk), .aresetn(aresetn), .enable(enable[3]),
    .cfg_re_min(re_min[3]), .cfg_im_min(im_min[3]), .cfg_re_step(re_step[3]), .cfg_im_step(im_step[3]),
    .out_stream_tdata(tdata[3]), .out_stream_tkeep(tkeep[3]), .out_stream_tlast(tlast[3]),
    .out_stream_tuser(tuser[3]), .out_stream_tvalid(tvalid[3]), .out_stream_tready(tready[3]),
    .busy(busy[3]), .frame_done(fdone[3]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, k, act, exp);
    end
  endtask

  // Escape-time model in plain real arithmetic: beat value and number of iteration cycles.
  function automatic void model_px(input real cr, input real ci, input int mi,
                                   output logic [31:0] beat, output int iters);
    real zr, zi, t;
    bit done;
    zr = 0.0; zi = 0.0; done = 1'b0;
    beat = 32'h0; iters = mi;
    for (int i = 0; i < mi; i++) begin
      if (!done) begin
        if (zr * zr + zi * zi > 4.0) begin
          beat  = {8'(i), 8'(2 * i), 8'(255 - i), 8'h00};
          iters = i + 1;
          done  = 1'b1;
        end else begin
          t  = zr * zr - zi * zi + cr;
          zi = 2.0 * zr * zi + ci;
          zr = t;
        end
      end
    end
  endfunction

  function automatic logic signed [31:0] fx(input real v);
    fx = 32'($rtoi(v * ONE));
  endfunction

  task automatic set_cfg(input int k, input real rm, input real rs);
    re_min[k] = fx(rm); re_step[k] = fx(rs); im_min[k] = 32'sd0; im_step[k] = 32'sd0;
    f_rm[k] = rm; f_rs[k] = rs; f_im[k] = 0.0; f_is[k] = 0.0;
  endtask

  task automatic wait_beats(input int k, input int n);
    int c;
    c = 0;
    do begin
      @(posedge aclk);
      c++;
    end while (beats[k] < n && c < 5000);
    #1;
    chk("wait_beats", k, 32'(beats[k] >= n), 32'd1);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    for (int k = 0; k < N; k++) begin
      px[k] = 0; py[k] = 0; beats[k] = 0; since[k] = 0;
      gap_ok[k] = 1'b0; pv[k] = 1'b0; pr[k] = 1'b0; pl[k] = 1'b0; pu[k] = 1'b0; pd[k] = 32'h0;
      fd_exp[k] = 1'b0;
    end
    forever begin
      @(negedge aclk);
      for (int k = 0; k < N; k++) begin
        if (!aresetn) begin
          px[k] = 0; py[k] = 0; gap_ok[k] = 1'b0; pv[k] = 1'b0; fd_exp[k] = 1'b0; since[k] = 0;
        end else begin
          since[k]++;
          chk("frame_done", k, 32'(fdone[k]), 32'(fd_exp[k]));
          fd_exp[k] = 1'b0;
          if (pv[k] && !pr[k]) begin
            chk("stall_valid", k, 32'(tvalid[k]), 32'd1);
            chk("stall_data", k, tdata[k], pd[k]);
            chk("stall_last", k, 32'(tlast[k]), 32'(pl[k]));
            chk("stall_user", k, 32'(tuser[k]), 32'(pu[k]));
          end
          model_px(f_rm[k] + real'(px[k]) * f_rs[k], f_im[k] + real'(py[k]) * f_is[k], MI[k], m_beat, m_it);
          if (tvalid[k] && !pv[k] && gap_ok[k]) begin
            chk("latency", k, 32'(since[k]), 32'(m_it + 2));
            gap_ok[k] = 1'b0;
          end
          if (tvalid[k] && tready[k]) begin
            chk("tdata", k, tdata[k], m_beat);
            chk("tkeep", k, 32'(tkeep[k]), 32'hF);
            chk("tuser", k, 32'(tuser[k]), 32'(px[k] == 0 && py[k] == 0));
            chk("tlast", k, 32'(tlast[k]),
                32'(px[k] == XS[k] - 1 && (k != 1 || py[k] == YS[k] - 1)));
            beats[k]++;
            since[k] = 0;
            fd_exp[k] = (px[k] == XS[k] - 1) && (py[k] == YS[k] - 1);
            gap_ok[k] = !fd_exp[k] || enable[k];
            if (px[k] < XS[k] - 1) begin
              px[k]++;
            end else begin
              px[k] = 0;
              py[k] = (py[k] < YS[k] - 1) ? py[k] + 1 : 0;
            end
          end
          pv[k] = tvalid[k]; pr[k] = tready[k]; pd[k] = tdata[k]; pl[k] = tlast[k]; pu[k] = tuser[k];
        end
      end
    end
  end

  // Random back-pressure on instance 0 while stall_on is set.
  initial begin
    hold = 0;
    forever begin
      @(posedge aclk);
      #1;
      if (stall_on) begin
        if (hold > 0) begin
          tready[0] = 1'b0;
          hold--;
        end else begin
          tready[0] = 1'b1;
          hold = $urandom_range(0, 10);
        end
      end else begin
        tready[0] = 1'b1;
      end
    end
  end

  initial begin
    aresetn = 1'b0;
    stall_on = 1'b0;
    for (int k = 0; k < N; k++) begin
      enable[k] = 1'b0; tready[k] = 1'b1;
      set_cfg(k, 0.0, 0.0);
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_tvalid", k, 32'(tvalid[k]), 32'd0);
      chk("rst_tdata", k, tdata[k], 32'h0);
      chk("rst_tlast", k, 32'(tlast[k]), 32'd0);
      chk("rst_tuser", k, 32'(tuser[k]), 32'd0);
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_frame_done", k, 32'(fdone[k]), 32'd0);
      chk("rst_tkeep", k, 32'(tkeep[k]), 32'hF);
    end

    // Hand-computed pins on the model itself.
    model_px(1.0, 0.0, 16, p_beat, p_it);
    chk("pin_c1", 0, p_beat, 32'h0306FC00);
    chk("pin_c1_iters", 0, 32'(p_it), 32'd4);
    model_px(2.0, 0.0, 16, p_beat, p_it);
    chk("pin_c2", 0, p_beat, 32'h0204FD00);
    chk("pin_c2_iters", 0, 32'(p_it), 32'd3);
    model_px(-2.0, 0.0, 16, p_beat, p_it);
    chk("pin_cm2", 0, p_beat, 32'h0);
    chk("pin_cm2_iters", 0, 32'(p_it), 32'd16);
    model_px(1.0, 0.0, 1, p_beat, p_it);
    chk("pin_max1", 0, p_beat, 32'h0);

    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    set_cfg(0, -2.0, 1.0);
    set_cfg(1, -2.0, 1.0);
    set_cfg(2, 2.0, 0.0);
    set_cfg(3, -2.0, 1.0);
    @(posedge aclk);
    #1;
    for (int k = 0; k < N; k++) enable[k] = 1'b1;

    // Instances 1 and 3 run exactly one frame; instance 2 runs back-to-back 1x1 frames.
    wait_beats(1, 1); enable[1] = 1'b0;
    wait_beats(3, 1); enable[3] = 1'b0;
    wait_beats(2, 3); enable[2] = 1'b0;
    wait_beats(1, 8);
    wait_beats(3, 8);
    wait_beats(0, 8);

    // Back-pressure over two full frames.
    stall_on = 1'b1;
    wait_beats(0, 24);
    stall_on = 1'b0;

    // Drop enable mid-frame and change cfg; the frame must finish with the old cfg.
    wait_beats(0, 26);
    enable[0] = 1'b0;
    re_min[0] = fx(-1.0);
    wait_beats(0, 32);
    repeat (40) @(posedge aclk);
    #1;
    chk("idle_tvalid", 0, 32'(tvalid[0]), 32'd0);
    chk("idle_busy", 0, 32'(busy[0]), 32'd0);
    chk("idle_beats", 0, 32'(beats[0]), 32'd32);
    f_rm[0] = -1.0;
    enable[0] = 1'b1;

    // Reset while beat 5 of the new frame is iterating.
    wait_beats(0, 37);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    chk("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 0, 32'(tvalid[0]), 32'd0);
    chk("arst_busy", 0, 32'(busy[0]), 32'd0);
    chk("arst_tdata", 0, tdata[0], 32'h0);
    chk("arst_tlast", 0, 32'(tlast[0]), 32'd0);
    chk("arst_tuser", 0, 32'(tuser[0]), 32'd0);
    chk("arst_frame_done", 0, 32'(fdone[0]), 32'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    wait_beats(0, 38);
    enable[0] = 1'b0;
    wait_beats(0, 45);
    repeat (40) @(posedge aclk);
    #1;
    chk("final_beats0", 0, 32'(beats[0]), 32'd45);
    chk("final_beats1", 1, 32'(beats[1]), 32'd8);
    chk("final_beats3", 3, 32'(beats[3]), 32'd8);
    chk("final_tvalid0", 0, 32'(tvalid[0]), 32'd0);
    chk("final_busy0", 0, 32'(busy[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_stream_gen.md
Name: mandel_stream_gen

Overview:
Synthesizable, parametrised Mandelbrot pixel-stream source. It replaces the behavioural real-arithmetic test streamer with a fixed-point iterative engine: it walks an X_SIZE×Y_SIZE raster, iterates z←z²+c for each pixel, maps the escape count to RGB, and emits one AXI4-Stream video beat per pixel. The viewport is runtime-configurable and the tlast convention is selectable. It sits upstream of the VDMA/video-out path.

Parameters:
X_SIZE, 640, pixels per line (≥1)
Y_SIZE, 480, lines per frame (≥1)
MAX_ITER, 255, iteration limit (1..255)
DATA_W, 32, signed fixed-point width of c/z
FRAC_BITS, 28, fractional bits; DATA_W-FRAC_BITS ≥ 4 is required
TLAST_MODE, 1, 1 = tlast at end of line; 0 = tlast at end of frame

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  run frames while high
cfg_re_min  in  DATA_W  signed Re(c) of x=0
cfg_im_min  in  DATA_W  signed Im(c) of y=0
cfg_re_step  in  DATA_W  signed Re increment per pixel
cfg_im_step  in  DATA_W  signed Im increment per line
out_stream_tdata  out  32  {R,G,B,8'h00}
out_stream_tkeep  out  4  always 4'b1111
out_stream_tlast  out  1  per TLAST_MODE
out_stream_tuser  out  1  start of frame (pixel 0,0)
out_stream_tvalid  out  1  beat valid
out_stream_tready  in  1  sink ready
busy  out  1  high when not in IDLE
frame_done  out  1  one-cycle pulse on the last beat's handshake

Behaviour:
- Reset: aresetn is asynchronous and active-low; clock is aclk. Reset forces state=IDLE, x=0, y=0, tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, frame_done=0. tkeep is a constant 4'hF.
- FSM states are IDLE, LOAD, ITER, OUT.
- IDLE: when enable=1, latch all cfg_*. Set cr=cfg_re_min and ci=cfg_im_min. Go to LOAD.
- cfg_* changes mid-frame are ignored until the next frame start.
- LOAD (1 cycle): zr=zi=0, i=0. Go to ITER.
- ITER (1 iteration/cycle):
  - Compute full-precision products zr², zi², zr·zi at 2·DATA_W width.
  - Escape when zr²+zi² > 4.0. The compare is done at full precision (2·DATA_W+1 bits). Equality does not escape.
  - On escape: color=palette(i), go to OUT.
  - Else if i==MAX_ITER-1: color=24'h000000, go to OUT.
  - Else:
    - zr ← ((zr²-zi²)>>>FRAC_BITS) + cr
    - zi ← ((2·zr·zi)>>>FRAC_BITS) + ci
    - Both are truncated to DATA_W. i++.
  - ITER cycles per pixel: i+1 on escape at i; MAX_ITER when the pixel is in the set.
- palette(i), 8-bit modulo: R=i, G=(2i)&8'hFF, B=255-i.
- OUT:
  - Drive the registered beat with tvalid=1.
  - tuser=(x==0&&y==0).
  - tlast: TLAST_MODE=1 → x==X_SIZE-1; TLAST_MODE=0 → x==X_SIZE-1&&y==Y_SIZE-1.
  - Hold tdata, tlast and tuser stable while tvalid&!tready.
- On handshake (tvalid&tready), tvalid drops the next cycle and coordinates advance:
  - Not end of line: x++, cr+=re_step.
  - End of line, not last line: x=0, cr=re_min, y++, ci+=im_step.
  - Last pixel of frame: x=y=0 and frame_done pulses. If enable=1, re-latch cfg and go to LOAD; else go to IDLE.
  - Otherwise go to LOAD.
- enable deassert mid-frame: the frame completes fully, then the block goes to IDLE. No partial frames are ever emitted.
- No bubbles other than the per-pixel compute time. Per-pixel latency from handshake to next tvalid = 1 (LOAD) + ITER cycles + 1.
- Reset mid-operation: immediate abort. The next frame starts at (0,0) with tuser=1.
- Coordinate counters are sized $clog2(X_SIZE), $clog2(Y_SIZE) (min 1 bit).

Test Plan:
1. X_SIZE=4, Y_SIZE=2, MAX_ITER=16, FRAC_BITS=28, re_min=-2.0, re_step=1.0, im_min=0, im_step=0, tready=1 → 8 beats. Each row is 0x00000000, 0x00000000, 0x00000000, 0x0306FC00 (c=1 escapes at i=3). tuser only on beat 0. TLAST_MODE=1: tlast on beats 3 and 7. Rerun with TLAST_MODE=0: tlast on beat 7 only. frame_done pulses once per frame.
2. Same config with re_min=2.0, re_step=0, X_SIZE=1, Y_SIZE=1 → 0x0204FD00 (escape at i=2). ITER lasts 3 cycles; tvalid rises 5 cycles after entering LOAD.
3. Random tready stalls (up to 10 cycles) over a full 4×2 frame → tdata/tlast/tuser stable during stall, beat sequence identical to scenario 1, no beats lost or duplicated.
4. MAX_ITER=1, any config → every pixel black, exactly 1 ITER cycle per pixel.
5. enable dropped at beat 2 and cfg_re_min changed mid-frame → frame finishes with the old cfg, tvalid stays 0 afterwards, busy=0. Re-asserting enable starts a new frame with the new cfg and tuser=1 on its first beat.
6. aresetn pulsed low during ITER of beat 5 → all outputs return to reset values at once. After release with enable=1, the first beat is (0,0) with tuser=1.
